// File: rtl/dbus_ic.sv
// rtl/dbus_ic.sv - data-bus interconnect: slave decode, byte strobes, load alignment
//
// Routes one core load/store at a time to one of NS slaves selected by
// m_addr[AW+2:AW]. Stores are presented as replicated data with byte
// strobes; loads come back as whole words and are aligned and sign- or
// zero-extended here. Misaligned, illegal-type and unmapped accesses are
// answered with an error and never reach a slave.
//
// Optional feature macro: DBUS_TIMEOUT_EN (abort a silent slave after TO_CYC cycles).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   m_req_*, m_we, m_addr, m_wdata, m_rw_type   core request side
//   m_rsp_valid/rdata/err                       core response (one-cycle pulse)
//   s_req (one-hot), s_we, s_addr, s_wdata, s_wstrb  shared slave request bus
//   s_rsp_valid[NS], s_rdata[NS*32]             per-slave completion and read word
module dbus_ic #(
    parameter int NS     = 2,
    parameter int AW     = 18,
    parameter int TO_CYC = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_req_valid,
    output logic             m_req_ready,
    input  logic             m_we,
    input  logic [31:0]      m_addr,
    input  logic [31:0]      m_wdata,
    input  logic [2:0]       m_rw_type,
    output logic             m_rsp_valid,
    output logic [31:0]      m_rsp_rdata,
    output logic             m_rsp_err,
    output logic [NS-1:0]    s_req,
    output logic             s_we,
    output logic [AW-1:0]    s_addr,
    output logic [31:0]      s_wdata,
    output logic [3:0]       s_wstrb,
    input  logic [NS-1:0]    s_rsp_valid,
    input  logic [NS*32-1:0] s_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    type_q, type_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    sel_q, sel_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
`ifdef DBUS_TIMEOUT_EN
    logic [7:0]    cnt_q, cnt_d;
    logic          unused_addr;
    assign unused_addr = ^m_addr[31:AW+3];
`else
    logic          unused_cfg;
    assign unused_cfg = ^{m_addr[31:AW+3], 8'(TO_CYC)};
`endif

    // Request-side decode, evaluated combinationally in the accept cycle.
    logic [2:0]  req_idx;
    logic        req_err;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;

    assign req_idx = m_addr[AW+2:AW];

    always_comb begin
        req_err = (m_rw_type == 3'b011) || (m_rw_type[2:1] == 2'b11)
               || (m_rw_type[1:0] == 2'b01 && m_addr[0])
               || (m_rw_type[1:0] == 2'b10 && m_addr[1:0] != 2'b00)
               || (32'(req_idx) >= NS);
        case (m_rw_type[1:0])
            2'b00: begin
                req_strb  = 4'b0001 << m_addr[1:0];
                req_wdata = {4{m_wdata[7:0]}};
            end
            2'b01: begin
                req_strb  = 4'b0011 << m_addr[1:0];
                req_wdata = {2{m_wdata[15:0]}};
            end
            default: begin
                req_strb  = 4'b1111;
                req_wdata = m_wdata;
            end
        endcase
    end

    // Selected-slave mux; also drives the one-hot request in ISSUE.
    logic        rsp_sel;
    logic [31:0] rd_sel;

    always_comb begin
        s_req   = '0;
        rsp_sel = 1'b0;
        rd_sel  = '0;
        for (int k = 0; k < NS; k++) begin
            if (sel_q == 3'(k)) begin
                s_req[k] = (state_q == ISSUE);
                rsp_sel  = s_rsp_valid[k];
                rd_sel   = s_rdata[32*k +: 32];
            end
        end
    end

    // Load alignment: shift the addressed lane down to bit 0, then extend.
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign shifted = rd_sel >> {off_q, 3'b000};

    always_comb begin
        case (type_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = rd_sel;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        type_d  = type_q;
        off_d   = off_q;
        sel_d   = sel_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
`ifdef DBUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (m_req_valid && m_req_ready) begin
                    we_d    = m_we;
                    type_d  = m_rw_type;
                    off_d   = m_addr[1:0];
                    sel_d   = req_idx;
                    err_d   = req_err;
                    rdata_d = '0;
`ifdef DBUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        // Slave bus fields only change for accesses that will be issued.
                        addr_d  = {m_addr[AW-1:2], 2'b00};
                        wdata_d = req_wdata;
                        wstrb_d = m_we ? req_strb : 4'b0000;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE, WAIT: begin
`ifdef DBUS_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (rsp_sel) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : load_data;
                end
`ifdef DBUS_TIMEOUT_EN
                else if (cnt_q + 8'd1 == 8'(TO_CYC)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
`endif
                else begin
                    state_d = WAIT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            type_q  <= '0;
            off_q   <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
`ifdef DBUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            type_q  <= type_d;
            off_q   <= off_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
`ifdef DBUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign m_req_ready = (state_q == IDLE) && !rst;
    assign m_rsp_valid = (state_q == RESP);
    assign m_rsp_err   = err_q && (state_q == RESP);
    assign m_rsp_rdata = rdata_q;
    assign s_we        = we_q;
    assign s_addr      = addr_q;
    assign s_wdata     = wdata_q;
    assign s_wstrb     = wstrb_q;

endmodule

// File: tb/tb_dbus_ic.sv
// tb/tb_dbus_ic.sv - self-checking bench for dbus_ic with a behavioural reference model
module tb_dbus_ic;

    localparam int NS = 2;
    localparam int AW = 18;
    localparam int TO = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             m_req_valid = 1'b0;
    logic             m_req_ready;
    logic             m_we = 1'b0;
    logic [31:0]      m_addr = '0;
    logic [31:0]      m_wdata = '0;
    logic [2:0]       m_rw_type = '0;
    logic             m_rsp_valid;
    logic [31:0]      m_rsp_rdata;
    logic             m_rsp_err;
    logic [NS-1:0]    s_req;
    logic             s_we;
    logic [AW-1:0]    s_addr;
    logic [31:0]      s_wdata;
    logic [3:0]       s_wstrb;
    logic [NS-1:0]    s_rsp_valid = '0;
    logic [NS*32-1:0] s_rdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbus_ic #(.NS(NS), .AW(AW), .TO_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rw_type(m_rw_type),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rsp_valid(s_rsp_valid), .s_rdata(s_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction against a slave that answers 'lat' cycles after ISSUE.
    // Expected behaviour is derived from access size/offset arithmetic.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] typ, input int lat, input logic [31:0] rword);
        int          idx, off, size, rcyc;
        logic        e;
        logic [31:0] strb_e, wdat_e, rdat_e, mask, sa_e;
        logic [NS-1:0] oh;
        idx  = int'(addr[AW+2:AW]);
        off  = int'(addr[1:0]);
        size = (typ[1:0] == 2'b00) ? 1 : (typ[1:0] == 2'b01) ? 2 : 4;
        e    = (typ == 3'b011) || (typ >= 3'b110) || (off % size != 0) || (idx >= NS);
        strb_e = we ? ((((32'd1 << size) - 1) << off) & 32'hF) : 32'd0;
        for (int b = 0; b < 4; b++) wdat_e[8*b +: 8] = wd[8*(b % size) +: 8];
        mask   = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 1);
        rdat_e = (rword >> (8*off)) & mask;
        if (size < 4 && !typ[2] && rdat_e[8*size-1]) rdat_e = rdat_e | ~mask;
        if (we || e) rdat_e = 32'd0;
        sa_e = addr & (((32'd1 << AW) - 1) & ~32'd3);
        oh = '0;
        if (!e) oh[idx] = 1'b1;
        rcyc = e ? 1 : 2 + lat;

        @(negedge clk);
        m_req_valid = 1'b1; m_we = we; m_addr = addr; m_wdata = wd; m_rw_type = typ;
        for (int k = 0; k < NS; k++) s_rsp_valid[k] = (($urandom % 2) == 1) && (k != idx);
        for (int c = 1; c <= rcyc; c++) begin
            @(negedge clk);
            m_req_valid = 1'b0;
            m_addr = $urandom;
            check("rsp_valid", m_rsp_valid, c == rcyc);
            check("req_ready", m_req_ready, 0);
            check("s_req", s_req, (c == 1) ? oh : '0);
            if (!e && c < rcyc) begin
                check("s_addr", s_addr, sa_e);
                check("s_we", s_we, we);
                check("s_wstrb", s_wstrb, strb_e);
                if (we) check("s_wdata", s_wdata, wdat_e);
            end
            if (c == rcyc) begin
                check("rsp_err", m_rsp_err, e);
                check("rsp_rdata", m_rsp_rdata, rdat_e);
            end
            for (int k = 0; k < NS; k++) begin
                s_rdata[32*k +: 32] = $urandom;
                s_rsp_valid[k] = ($urandom % 2) == 1;
                if (k == idx) begin
                    s_rdata[32*k +: 32] = rword;
                    s_rsp_valid[k] = (!e && c == 1 + lat) || (c == rcyc && ($urandom % 2) == 1);
                end
            end
        end
        @(negedge clk);
        s_rsp_valid = '0;
        check("idle_ready", m_req_ready, 1);
        check("idle_rsp", m_rsp_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_ready", m_req_ready, 0);
        check("rst_sreq", s_req, 0);
        check("rst_rspv", m_rsp_valid, 0);
        check("rst_err", m_rsp_err, 0);
        check("rst_rdata", m_rsp_rdata, 0);
        check("rst_wstrb", s_wstrb, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", m_req_ready, 1);

        // Directed cases
        do_txn(1'b1, 32'h0000_0104, 32'h1234_5678, 3'b010, 1, 32'h0);
        do_txn(1'b1, 32'h0004_0003, 32'h0000_00AB, 3'b000, 0, 32'h0);
        do_txn(1'b0, 32'h0000_0002, 32'h0,         3'b001, 1, 32'h80FF_7F01);
        do_txn(1'b0, 32'h0004_0002, 32'h0,         3'b101, 2, 32'h80FF_7F01);
        do_txn(1'b0, 32'h0000_0000, 32'h0,         3'b000, 0, 32'h80FF_7F01);
        do_txn(1'b1, 32'h0000_0006, 32'h0000_BEEF, 3'b001, 3, 32'h0);
        do_txn(1'b0, 32'h0000_0102, 32'h0,         3'b010, 0, 32'h0);
        do_txn(1'b0, 32'h0000_0100, 32'h0,         3'b011, 0, 32'h0);
        do_txn(1'b0, 32'h000C_0000, 32'h0,         3'b010, 0, 32'h0);
        do_txn(1'b0, 32'h0000_0101, 32'h0,         3'b101, 0, 32'h0);

        // Silent slave 0 (slave 1 keeps signalling, which must be ignored)
        @(negedge clk);
        m_req_valid = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0100; m_rw_type = 3'b010;
        s_rsp_valid = 2'b10;
`ifdef DBUS_TIMEOUT_EN
        for (int c = 1; c <= TO + 1; c++) begin
            @(negedge clk);
            m_req_valid = 1'b0;
            check("to_valid", m_rsp_valid, c == TO + 1);
        end
        check("to_err", m_rsp_err, 1);
        check("to_rdata", m_rsp_rdata, 0);
        s_rsp_valid = 2'b01;
        @(negedge clk);
        s_rsp_valid = '0;
        check("late_ignored", m_rsp_valid, 0);
        check("late_ready", m_req_ready, 1);
        m_req_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            m_req_valid = 1'b0;
        end
`else
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            m_req_valid = 1'b0;
            check("hang_valid", m_rsp_valid, 0);
            check("hang_ready", m_req_ready, 0);
        end
`endif
        // Reset while waiting on the slave
        rst = 1'b1;
        m_req_valid = 1'b1;
        #1;
        check("wrst_ready", m_req_ready, 0);
        check("wrst_sreq", s_req, 0);
        check("wrst_rspv", m_rsp_valid, 0);
        @(negedge clk);
        check("wrst_ready2", m_req_ready, 0);
        rst = 1'b0;
        m_req_valid = 1'b0;
        s_rsp_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("wrst_no_rsp", m_rsp_valid, 0);
        end

        // Reset in the ISSUE cycle drops s_req at once
        m_req_valid = 1'b1; m_we = 1'b1; m_addr = 32'h0004_0000; m_rw_type = 3'b010;
        @(negedge clk);
        m_req_valid = 1'b0;
        check("iss_sreq", s_req, 2'b10);
        rst = 1'b1;
        #1;
        check("irst_sreq", s_req, 0);
        check("irst_rspv", m_rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("irst_ready", m_req_ready, 1);
        check("irst_no_rsp", m_rsp_valid, 0);
        do_txn(1'b0, 32'h0004_0001, 32'h0, 3'b100, 1, 32'hDEAD_BEEF);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            a[AW+2:AW] = 3'($urandom_range(0, 2));
            do_txn(($urandom % 2) == 1, a, $urandom, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
